// File: rtl/machdem_xuong.sv
// Synchronous modulo-MOD down counter built from a borrow-rippled toggle chain,
// with parallel load, count enable and cascadable borrow in/out.
module machdem_xuong #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MOD   = 16
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             en,
    input  logic             bi,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             bo
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 1);

    logic             ce;
    logic [WIDTH-1:0] tgl;
    logic [WIDTH-1:0] q_next;

    assign ce   = en & bi;
    assign zero = (q == '0);
    assign bo   = ce & zero;

    // Stage i toggles when counting and every lower stage is already 0
    always_comb begin
        tgl = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            tgl[i] = ce & ~|(q & WIDTH'((1 << i) - 1));
        end
    end

    // Load beats wrap beats decrement; the wrap also covers non power-of-two MOD
    always_comb begin
        q_next = q ^ tgl;
        if (ld) begin
            q_next = (d > TOP) ? TOP : d;
        end else if (ce && zero) begin
            q_next = TOP;
        end
    end

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: tb/tb_machdem_xuong.sv
// Self-checking bench for machdem_xuong: directed scenarios plus randomized
// traffic compared against an arithmetic modulo-counter model.
module tb_machdem_xuong;

    logic       clk;
    logic       rs;
    logic       a_en, a_bi, a_ld;
    logic [3:0] a_d, a_q;
    logic       a_zero, a_bo;
    logic       b_en, b_bi, b_ld;
    logic [3:0] b_d, b_q;
    logic       b_zero, b_bo;
    logic       lo_en, lo_bi, lo_ld, hi_en, hi_ld;
    logic [3:0] lo_d, lo_q, hi_d, hi_q;
    logic       lo_zero, lo_bo, hi_zero, hi_bo;

    int checks;
    int errors;
    int qa;
    int qb;

    machdem_xuong #(.WIDTH(4), .MOD(16)) dut_a (
        .clk(clk), .rs(rs), .en(a_en), .bi(a_bi), .ld(a_ld), .d(a_d),
        .q(a_q), .zero(a_zero), .bo(a_bo)
    );

    machdem_xuong #(.WIDTH(4), .MOD(10)) dut_b (
        .clk(clk), .rs(rs), .en(b_en), .bi(b_bi), .ld(b_ld), .d(b_d),
        .q(b_q), .zero(b_zero), .bo(b_bo)
    );

    machdem_xuong #(.WIDTH(4), .MOD(16)) dut_lo (
        .clk(clk), .rs(rs), .en(lo_en), .bi(lo_bi), .ld(lo_ld), .d(lo_d),
        .q(lo_q), .zero(lo_zero), .bo(lo_bo)
    );

    machdem_xuong #(.WIDTH(4), .MOD(16)) dut_hi (
        .clk(clk), .rs(rs), .en(hi_en), .bi(lo_bo), .ld(hi_ld), .d(hi_d),
        .q(hi_q), .zero(hi_zero), .bo(hi_bo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_next(int q, int m, bit ld, int d, bit ce);
        if (ld) return (d > m - 1) ? m - 1 : d;
        if (ce) return (q + m - 1) % m;
        return q;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rs = 1'b0;
        a_ld = 1'b1; a_d = 4'd5; a_en = 1'b1; a_bi = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (a_q !== 4'd0 || a_zero !== 1'b1 || a_bo !== 1'b1) begin
                errors++;
                $display("FAIL reset_hold: q=%0d zero=%b bo=%b required q=0 zero=1 bo=1", a_q, a_zero, a_bo);
            end
        end
        a_en = 1'b0;
        #1;
        checks++;
        if (a_bo !== 1'b0) begin
            errors++;
            $display("FAIL reset_bo_gated: bo=%b required 0", a_bo);
        end
        rs = 1'b1;
        a_ld = 1'b0; a_en = 1'b1; a_bi = 1'b1;
        step();
        qa = 15; qb = 0;
        checks++;
        if (a_q !== 4'd15) begin
            errors++;
            $display("FAIL reset_first_wrap: q=%0d required 15", a_q);
        end
    endtask

    task automatic test_count16();
        a_ld = 1'b1; a_d = 4'd0;
        step();
        a_ld = 1'b0;
        qa = 0;
        for (int k = 0; k < 17; k++) begin
            checks++;
            if (a_bo !== (qa == 0) || a_zero !== (qa == 0)) begin
                errors++;
                $display("FAIL count16_bo: q=%0d bo=%b zero=%b required bo=zero=%b", qa, a_bo, a_zero, qa == 0);
            end
            step();
            qa = (qa == 0) ? 15 : qa - 1;
            checks++;
            if (a_q !== 4'(qa)) begin
                errors++;
                $display("FAIL count16_q: edge %0d q=%0d required %0d", k, a_q, qa);
            end
        end
    endtask

    task automatic test_mod10();
        b_ld = 1'b1; b_d = 4'd12; b_en = 1'b0; b_bi = 1'b1;
        step();
        qb = 9;
        checks++;
        if (b_q !== 4'd9) begin
            errors++;
            $display("FAIL mod10_clamp: q=%0d required 9", b_q);
        end
        b_ld = 1'b0; b_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            qb = (qb == 0) ? 9 : qb - 1;
            checks++;
            if (b_q !== 4'(qb)) begin
                errors++;
                $display("FAIL mod10_count: edge %0d q=%0d required %0d", k, b_q, qb);
            end
        end
        b_en = 1'b0; b_ld = 1'b1; b_d = 4'd3;
        step();
        b_ld = 1'b0;
        qb = 3;
        checks++;
        if (b_q !== 4'd3) begin
            errors++;
            $display("FAIL mod10_load: q=%0d required 3", b_q);
        end
    endtask

    task automatic test_load_priority();
        a_ld = 1'b1; a_d = 4'd0; a_en = 1'b0;
        step();
        a_d = 4'd7; a_en = 1'b1; a_bi = 1'b1;
        #1;
        checks++;
        if (a_bo !== 1'b1) begin
            errors++;
            $display("FAIL ldwrap_bo: bo=%b required 1", a_bo);
        end
        step();
        checks++;
        if (a_q !== 4'd7) begin
            errors++;
            $display("FAIL ldwrap_q: q=%0d required 7", a_q);
        end
        a_ld = 1'b0; a_en = 1'b0;
        for (int k = 0; k < 5; k++) step();
        checks++;
        if (a_q !== 4'd7) begin
            errors++;
            $display("FAIL hold_en0: q=%0d required 7", a_q);
        end
        a_en = 1'b1; a_bi = 1'b0;
        for (int k = 0; k < 3; k++) step();
        checks++;
        if (a_q !== 4'd7) begin
            errors++;
            $display("FAIL hold_bi0: q=%0d required 7", a_q);
        end
        a_en = 1'b0; a_bi = 1'b1;
        qa = 7;
    endtask

    task automatic test_cascade();
        int exp;
        lo_ld = 1'b1; lo_d = 4'd0; hi_ld = 1'b1; hi_d = 4'd0;
        lo_en = 1'b0; lo_bi = 1'b1; hi_en = 1'b1;
        step();
        lo_ld = 1'b0; hi_ld = 1'b0; lo_en = 1'b1;
        exp = 0;
        for (int k = 0; k < 257; k++) begin
            step();
            exp = (exp + 255) % 256;
            checks++;
            if ({hi_q, lo_q} !== 8'(exp)) begin
                errors++;
                $display("FAIL cascade: edge %0d value=%0d required %0d", k, {hi_q, lo_q}, exp);
            end
        end
        lo_en = 1'b0;
    endtask

    task automatic test_async_reset();
        a_ld = 1'b1; a_d = 4'd6; a_en = 1'b0;
        step();
        a_ld = 1'b0;
        checks++;
        if (a_q !== 4'd6) begin
            errors++;
            $display("FAIL areset_setup: q=%0d required 6", a_q);
        end
        a_en = 1'b1;
        #2 rs = 1'b0;
        #1;
        checks++;
        if (a_q !== 4'd0 || a_zero !== 1'b1) begin
            errors++;
            $display("FAIL areset_immediate: q=%0d zero=%b required q=0 zero=1", a_q, a_zero);
        end
        a_en = 1'b0;
        @(negedge clk);
        rs = 1'b1;
        a_ld = 1'b1; a_d = 4'd2;
        step();
        a_ld = 1'b0;
        qa = 2; qb = 0;
        checks++;
        if (a_q !== 4'd2 || b_q !== 4'd0) begin
            errors++;
            $display("FAIL areset_reload: a.q=%0d b.q=%0d required 2 and 0", a_q, b_q);
        end
    endtask

    task automatic test_random();
        int ea;
        int eb;
        for (int k = 0; k < 300; k++) begin
            a_ld = ($urandom_range(0, 7) == 0); a_d = 4'($urandom);
            a_en = 1'($urandom); a_bi = 1'($urandom);
            b_ld = ($urandom_range(0, 7) == 0); b_d = 4'($urandom);
            b_en = 1'($urandom); b_bi = 1'($urandom);
            #1;
            checks++;
            if (a_bo !== (a_en & a_bi & (qa == 0)) || b_bo !== (b_en & b_bi & (qb == 0))
                || a_zero !== (qa == 0) || b_zero !== (qb == 0)) begin
                errors++;
                $display("FAIL rand_comb: cyc %0d a.bo=%b a.zero=%b b.bo=%b b.zero=%b model qa=%0d qb=%0d",
                         k, a_bo, a_zero, b_bo, b_zero, qa, qb);
            end
            ea = model_next(qa, 16, a_ld, int'(a_d), a_en & a_bi);
            eb = model_next(qb, 10, b_ld, int'(b_d), b_en & b_bi);
            step();
            qa = ea; qb = eb;
            checks++;
            if (a_q !== 4'(qa) || b_q !== 4'(qb) || int'(b_q) > 9) begin
                errors++;
                $display("FAIL rand_q: cyc %0d a.q=%0d b.q=%0d required %0d and %0d", k, a_q, b_q, qa, qb);
            end
        end
        a_ld = 1'b0; b_ld = 1'b0; a_en = 1'b0; b_en = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; qa = 0; qb = 0;
        rs = 1'b0;
        a_en = 1'b0; a_bi = 1'b1; a_ld = 1'b0; a_d = 4'd0;
        b_en = 1'b0; b_bi = 1'b1; b_ld = 1'b0; b_d = 4'd0;
        lo_en = 1'b0; lo_bi = 1'b1; lo_ld = 1'b0; lo_d = 4'd0;
        hi_en = 1'b0; hi_ld = 1'b0; hi_d = 4'd0;
        test_reset();
        test_count16();
        test_mod10();
        test_load_priority();
        test_cascade();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
